// File: rtl/imm_extend_pipe.sv
//==============================================================================
// Module   : imm_extend_pipe
// Purpose  : Pipelined immediate extender for the decode stage. Turns an
//            IN_WIDTH immediate into a DATA_WIDTH operand using one of four
//            modes. A valid/ready handshake is used on both sides, with a
//            main register plus a one-entry skid register. This keeps full
//            throughput when the operand mux applies back-pressure.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset (synchronised release)
//            in_valid   immediate/mode valid
//            in_ready   block can accept this cycle
//            in_imm     raw immediate [IN_WIDTH]
//            in_mode    00 zext, 01 sext, 10 upper, 11 sext<<2
//            out_valid  out_data valid
//            out_ready  consumer takes out_data this cycle
//            out_data   extended operand [DATA_WIDTH]
//            out_neg    sign bit of the immediate behind out_data
//            ext_count  saturating accepted-transaction count [CNT_WIDTH]
//                       (present only when EXT_COUNT_EN is defined)
// Config   : `define EXT_COUNT_EN adds the ext_count port and counter
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module imm_extend_pipe #(
   parameter int IN_WIDTH   = 16,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_imm,
   input  logic [1:0]            in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_neg
`ifdef EXT_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  ext_count
`endif
);

   localparam int         c_ext         = DATA_WIDTH - IN_WIDTH;
   localparam logic [1:0] c_mode_zext   = 2'b00;
   localparam logic [1:0] c_mode_sext   = 2'b01;
   localparam logic [1:0] c_mode_upper  = 2'b10;
   localparam logic [1:0] c_mode_branch = 2'b11;

   // ---------------------------------------------------------------------
   // Reset synchroniser: assertion clears every flop at once, release is
   // aligned to clk. During the two release cycles, the pipeline is still
   // held in reset, so inputs offered then are not taken.
   // ---------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // ---------------------------------------------------------------------
   // Extension, evaluated on the live inputs so the result is captured
   // together with the immediate at accept time.
   // ---------------------------------------------------------------------
   logic                  w_sign;
   logic [DATA_WIDTH-1:0] w_zext;
   logic [DATA_WIDTH-1:0] w_sext;
   logic [DATA_WIDTH-1:0] w_upper;
   logic [DATA_WIDTH-1:0] w_branch;
   logic [DATA_WIDTH-1:0] w_ext;

   assign w_sign   = in_imm[IN_WIDTH-1];
   assign w_zext   = {{c_ext{1'b0}}, in_imm};
   assign w_sext   = {{c_ext{w_sign}}, in_imm};
   // IN_WIDTH + c_ext == DATA_WIDTH, so this is already the top DATA_WIDTH
   // bits of imm << c_ext for every legal IN_WIDTH.
   assign w_upper  = {in_imm, {c_ext{1'b0}}};
   assign w_branch = {w_sext[DATA_WIDTH-3:0], 2'b00};

   always_comb begin
      w_ext = w_zext;
      case (in_mode)
         c_mode_zext   : w_ext = w_zext;
         c_mode_sext   : w_ext = w_sext;
         c_mode_upper  : w_ext = w_upper;
         c_mode_branch : w_ext = w_branch;
         default       : w_ext = w_zext;
      endcase
   end

   // ---------------------------------------------------------------------
   // Main + skid storage
   // ---------------------------------------------------------------------
   logic                  r_main_valid;
   logic [DATA_WIDTH-1:0] r_main_data;
   logic                  r_main_neg;
   logic                  r_skid_valid;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic                  r_skid_neg;
   logic                  w_accept;
   logic                  w_xfer;

   // in_ready comes straight from a flop, with no path from out_ready.
   assign in_ready  = ~r_skid_valid;
   assign w_accept  = in_valid & in_ready;
   assign w_xfer    = r_main_valid & out_ready;

   assign out_valid = r_main_valid;
   assign out_data  = r_main_data;
   assign out_neg   = r_main_neg;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
         r_main_neg   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_neg   <= 1'b0;
      end else begin
         if (w_xfer && r_skid_valid) begin
            // Skid drains into main. in_ready is low, so no accept here.
            r_main_data  <= r_skid_data;
            r_main_neg   <= r_skid_neg;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            if (!r_main_valid || w_xfer) begin
               r_main_valid <= 1'b1;
               r_main_data  <= w_ext;
               r_main_neg   <= w_sign;
            end else begin
               r_skid_valid <= 1'b1;
               r_skid_data  <= w_ext;
               r_skid_neg   <= w_sign;
            end
         end else if (w_xfer) begin
            r_main_valid <= 1'b0;
         end
      end
   end

`ifdef EXT_COUNT_EN
   // ---------------------------------------------------------------------
   // Saturating accept counter
   // ---------------------------------------------------------------------
   localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_count <= '0;
      end else if (w_accept && (r_count != {CNT_WIDTH{1'b1}})) begin
         r_count <= r_count + c_cnt_one;
      end
   end

   assign ext_count = r_count;
`endif

endmodule

`default_nettype wire
